// File: rtl/alu_req_transmitter.sv
// alu_req_transmitter: queues ALU requests, applies per-request idle delay, drives ACT until ALU_RDY
module alu_req_transmitter #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int DELAY_WIDTH = 3,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   IN_VLD,
  output logic                   IN_RDY,
  input  logic [3:0]             IN_OP,
  input  logic [1:0]             IN_MOVI,
  input  logic [DATA_WIDTH-1:0]  IN_A,
  input  logic [DATA_WIDTH-1:0]  IN_B,
  input  logic [DATA_WIDTH-1:0]  IN_MEM,
  input  logic [DATA_WIDTH-1:0]  IN_IMM,
  input  logic [DELAY_WIDTH-1:0] IN_DELAY,
  output logic                   ACT,
  output logic [3:0]             OP,
  output logic [1:0]             MOVI,
  output logic [DATA_WIDTH-1:0]  REG_A,
  output logic [DATA_WIDTH-1:0]  REG_B,
  output logic [DATA_WIDTH-1:0]  MEM,
  output logic [DATA_WIDTH-1:0]  IMM,
  input  logic                   ALU_RDY,
  output logic [CNT_WIDTH-1:0]   SENT_CNT,
  output logic                   IDLE
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef struct packed {
    logic [3:0]            op;
    logic [1:0]            movi;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] mem;
    logic [DATA_WIDTH-1:0] imm;
  } req_t;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRIVE} state_t;
  req_t                   req_q [FIFO_DEPTH];
  logic [DELAY_WIDTH-1:0] dly_q [FIFO_DEPTH];
  logic [AW-1:0]          rd_q, wr_q, rd_d, wr_d, nx_rd;
  logic [AW:0]            cnt_q, cnt_d;
  state_t                 state_q;
  logic                   act_q;
  req_t                   out_q;
  logic [DELAY_WIDTH-1:0] wait_q;
  logic [CNT_WIDTH-1:0]   sent_q;
  logic                   push, pop;
  assign IN_RDY = cnt_q < FULL;
  assign push   = IN_VLD && IN_RDY;
  assign pop    = act_q && ALU_RDY;
  assign nx_rd  = rd_q + AW'(1);
  // queue bookkeeping: the head only leaves on acceptance
  always_comb begin
    rd_d  = pop ? nx_rd : rd_q;
    wr_d  = push ? wr_q + AW'(1) : wr_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  // storage needs no reset: validity is tracked by cnt_q
  always_ff @(posedge CLK) begin
    if (push) begin
      req_q[wr_q] <= {IN_OP, IN_MOVI, IN_A, IN_B, IN_MEM, IN_IMM};
      dly_q[wr_q] <= IN_DELAY;
    end
  end
  // pointer and occupancy registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  // sequencer: delay countdown, drive head until accepted, chain to next entry
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      act_q   <= 1'b0;
      out_q   <= '0;
      wait_q  <= '0;
      sent_q  <= '0;
    end else begin
      if (pop) sent_q <= sent_q + CNT_WIDTH'(1);
      case (state_q)
        S_IDLE: begin
          if (cnt_q != '0) begin
            if (dly_q[rd_q] == '0) begin
              state_q <= S_DRIVE;
              act_q   <= 1'b1;
              out_q   <= req_q[rd_q];
            end else begin
              state_q <= S_WAIT;
              wait_q  <= dly_q[rd_q];
            end
          end
        end
        S_WAIT: begin
          if (wait_q == DELAY_WIDTH'(1)) begin
            state_q <= S_DRIVE;
            act_q   <= 1'b1;
            out_q   <= req_q[rd_q];
          end else begin
            wait_q <= wait_q - DELAY_WIDTH'(1);
          end
        end
        S_DRIVE: begin
          if (ALU_RDY) begin
            if (cnt_q == (AW+1)'(1)) begin
              state_q <= S_IDLE;
              act_q   <= 1'b0;
            end else if (dly_q[nx_rd] == '0) begin
              out_q <= req_q[nx_rd];
            end else begin
              state_q <= S_WAIT;
              act_q   <= 1'b0;
              wait_q  <= dly_q[nx_rd];
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          act_q   <= 1'b0;
        end
      endcase
    end
  end
  assign ACT      = act_q;
  assign OP       = out_q.op;
  assign MOVI     = out_q.movi;
  assign REG_A    = out_q.a;
  assign REG_B    = out_q.b;
  assign MEM      = out_q.mem;
  assign IMM      = out_q.imm;
  assign SENT_CNT = sent_q;
  assign IDLE     = (cnt_q == '0) && !act_q;
endmodule

// File: tb/tb_alu_req_transmitter.sv
// tb_alu_req_transmitter: scoreboard bench with timing model for alu_req_transmitter
module tb_alu_req_transmitter;
  logic        CLK = 1'b0, RST_N = 1'b0, IN_VLD = 1'b0, ALU_RDY = 1'b0;
  logic        IN_RDY, ACT, IDLE;
  logic [3:0]  IN_OP = '0, OP;
  logic [1:0]  IN_MOVI = '0, MOVI;
  logic [7:0]  IN_A = '0, IN_B = '0, IN_MEM = '0, IN_IMM = '0;
  logic [7:0]  REG_A, REG_B, MEM, IMM;
  logic [2:0]  IN_DELAY = '0;
  logic [15:0] SENT_CNT;
  always #5 CLK = ~CLK;
  alu_req_transmitter dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VLD(IN_VLD), .IN_RDY(IN_RDY),
    .IN_OP(IN_OP), .IN_MOVI(IN_MOVI), .IN_A(IN_A), .IN_B(IN_B),
    .IN_MEM(IN_MEM), .IN_IMM(IN_IMM), .IN_DELAY(IN_DELAY),
    .ACT(ACT), .OP(OP), .MOVI(MOVI), .REG_A(REG_A), .REG_B(REG_B),
    .MEM(MEM), .IMM(IMM), .ALU_RDY(ALU_RDY), .SENT_CNT(SENT_CNT), .IDLE(IDLE)
  );
  // p = clock edge at which the request entered the queue
  typedef struct {
    logic [3:0] op;
    logic [1:0] movi;
    logic [7:0] a, b, mem, imm;
    int         d;
    int         p;
  } exp_t;
  exp_t        q[$];
  int          checks = 0, failures = 0;
  int          cyc = 0, last_e = 0, n_in, exp_start;
  logic [15:0] exp_sent = '0;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  // monitor: a request becomes drivable D cycles after both its push and the previous acceptance
  always @(negedge CLK) begin
    if (!RST_N) begin
      q.delete();
      last_e = 0;
      exp_sent = '0;
    end else begin
      n_in = 0;
      foreach (q[i]) if (q[i].p <= cyc) n_in++;
      chk("in_rdy", 64'(IN_RDY), 64'(n_in < 4));
      chk("idle", 64'(IDLE), 64'(n_in == 0));
      chk("sent_cnt", 64'(SENT_CNT), 64'(exp_sent));
      if (n_in == 0) chk("act_empty", 64'(ACT), 64'(0));
      else begin
        exp_start = ((q[0].p + 1 > last_e) ? q[0].p + 1 : last_e) + q[0].d;
        chk("act", 64'(ACT), 64'(cyc >= exp_start));
        if (ACT) begin
          chk("payload", 64'({OP, MOVI, REG_A, REG_B, MEM, IMM}),
              64'({q[0].op, q[0].movi, q[0].a, q[0].b, q[0].mem, q[0].imm}));
          if (ALU_RDY) begin
            last_e = cyc + 1;
            void'(q.pop_front());
            exp_sent++;
          end
        end
      end
    end
  end
  task automatic drive(input bit vld, input bit rdy, input logic [3:0] op, input logic [1:0] mv,
                       input logic [7:0] a, input logic [7:0] b, input int d, output bit ok);
    logic [7:0] m, im;
    m = 8'($urandom);
    im = 8'($urandom);
    IN_VLD = vld; ALU_RDY = rdy; IN_OP = op; IN_MOVI = mv;
    IN_A = a; IN_B = b; IN_MEM = m; IN_IMM = im; IN_DELAY = 3'(d);
    ok = vld && IN_RDY;
    if (ok) q.push_back('{op, mv, a, b, m, im, d, cyc + 1});
    @(posedge CLK);
    #1;
  endtask
  task automatic rnd(input bit vld, input bit rdy, input int d, output bit ok);
    drive(vld, rdy, 4'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), d, ok);
  endtask
  task automatic idle(input bit rdy, input int n);
    bit ok;
    for (int i = 0; i < n; i++) rnd(1'b0, rdy, 0, ok);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 300 && !(q.size() == 0 && IDLE); i++) idle(1'b1, 1);
    chk("drain", 64'(q.size()), 64'(0));
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end
  initial begin
    bit ok;
    int n, pushed;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_act", 64'(ACT), 64'(0));
    chk("rst_sent", 64'(SENT_CNT), 64'(0));
    chk("rst_rdy", 64'(IN_RDY), 64'(1));
    chk("rst_idle", 64'(IDLE), 64'(1));
    chk("rst_outs", 64'({OP, MOVI, REG_A, REG_B, MEM, IMM}), 64'(0));
    RST_N = 1'b1;
    idle(1'b0, 2);
    drive(1'b1, 1'b1, 4'h1, 2'd0, 8'h12, 8'h34, 0, ok);
    idle(1'b1, 1);
    chk("t1_act", 64'(ACT), 64'(1));
    chk("t1_ab", 64'({REG_A, REG_B}), 64'(16'h1234));
    idle(1'b1, 1);
    chk("t1_act_low", 64'(ACT), 64'(0));
    chk("t1_sent", 64'(SENT_CNT), 64'(1));
    chk("t1_idle", 64'(IDLE), 64'(1));
    rnd(1'b1, 1'b0, 3, ok);
    idle(1'b0, 5);
    wait_idle();
    for (int i = 0; i < 4; i++) rnd(1'b1, 1'b0, 0, ok);
    chk("full_rdy", 64'(IN_RDY), 64'(0));
    rnd(1'b1, 1'b0, 0, ok);
    chk("fifth_refused", 64'(ok), 64'(0));
    idle(1'b0, 2);
    wait_idle();
    rnd(1'b1, 1'b1, 0, ok);
    rnd(1'b1, 1'b1, 2, ok);
    rnd(1'b1, 1'b1, 0, ok);
    wait_idle();
    chk("mixed_sent", 64'(SENT_CNT), 64'(9));
    for (int i = 0; i < 3; i++) rnd(1'b1, 1'b0, 0, ok);
    idle(1'b0, 2);
    chk("pre_rst_act", 64'(ACT), 64'(1));
    RST_N = 1'b0;
    #1;
    chk("arst_act", 64'(ACT), 64'(0));
    chk("arst_sent", 64'(SENT_CNT), 64'(0));
    chk("arst_rdy", 64'(IN_RDY), 64'(1));
    chk("arst_idle", 64'(IDLE), 64'(1));
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    idle(1'b1, 8);
    for (int i = 0; i < 400; i++)
      rnd($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0, ok);
    wait_idle();
    n = 65535 - int'(exp_sent);
    pushed = 0;
    for (int i = 0; i < n + 1000 && pushed < n; i++) begin
      rnd(1'b1, 1'b1, 0, ok);
      pushed += int'(ok);
    end
    wait_idle();
    chk("sent_max", 64'(SENT_CNT), 64'(16'hFFFF));
    rnd(1'b1, 1'b1, 0, ok);
    wait_idle();
    chk("sent_wrap", 64'(SENT_CNT), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
